// File: rtl/mem_req_tracker_pkg.sv
// mem_req_tracker_pkg
// Shared definitions for the data-side request tracker:
//   - sram-like size codes (SIZE_B / SIZE_H / SIZE_W)
//   - outstanding-request FIFO entry layout and field widths
//   - issue FSM state encoding
package mem_req_tracker_pkg;

  // Byte-count codes carried on es_req_size / data_size
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Tracking FIFO entry field widths
  localparam int ENTRY_WR_W   = 1;
  localparam int ENTRY_KILL_W = 1;
  localparam int ENTRY_W      = ENTRY_WR_W + ENTRY_KILL_W;

  // One outstanding request: was it a store, and has it been flushed
  typedef struct packed {
    logic wr;
    logic kill;
  } req_entry_t;

  // Issue FSM: IDLE waits for an op, HOLD drives it on the bus until addr_ok
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/mem_req_tracker_fifo.sv
// req_track_fifo
// DEPTH x 2-bit FIFO of outstanding requests (addr_ok seen, data_ok pending).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   push, push_wr,
//   push_kill         : enqueue one entry (ignored when full)
//   pop               : dequeue head entry (ignored when empty)
//   kill_all          : mark every stored entry as killed
//   head_wr, head_kill: fields of the current head entry
//   count             : occupancy, 0..DEPTH
//   full, empty       : occupancy flags
module req_track_fifo
  import mem_req_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_wr,
  input  logic                     push_kill,
  input  logic                     pop,
  input  logic                     kill_all,
  output logic                     head_wr,
  output logic                     head_kill,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  req_entry_t        mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              do_push;
  logic              do_pop;
  req_entry_t        head;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign head_wr   = head.wr;
  assign head_kill = head.kill;
  assign count     = cnt;

  // kill_all touches every slot, including empty ones; a later push
  // overwrites the whole slot so a stale kill bit never leaks. The push
  // write comes after the kill loop so the new entry's own kill bit wins.
  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (kill_all) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i].kill <= 1'b1;
        end
      end
      if (do_push) begin
        mem[wr_ptr] <= '{wr: push_wr, kill: push_kill};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_tracker.sv
// mem_req_tracker
// Data-side request issuer/tracker between the execute stage and an
// sram-like data bus. Up to DEPTH requests may be outstanding; requests
// hit by a pipeline flush have their late responses swallowed.
// Optional feature macro: MEM_REQ_STALL_CNT_EN builds the stall counter;
// without it perf_stall_cnt is tied to 0.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   es_req_*              : op from execute stage (valid/ready handshake)
//   flush                 : exception/eret flush from ms/ws
//   data_req .. data_wstrb: sram-like request channel (driven from hold reg)
//   data_addr_ok          : request accepted by the bus
//   data_data_ok,
//   data_rdata            : response from the bus
//   ms_resp_valid/wr/rdata: one-cycle response to the memory stage
//   outstanding           : tracking FIFO occupancy
//   idle                  : nothing held and nothing outstanding
//   proto_err             : sticky, data_ok seen with nothing outstanding
//   perf_stall_cnt        : request-stall cycle counter
module mem_req_tracker
  import mem_req_tracker_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   es_req_valid,
  output logic                   es_req_ready,
  input  logic                   es_req_wr,
  input  logic [1:0]             es_req_size,
  input  logic [ADDR_W-1:0]      es_req_addr,
  input  logic [DATA_W-1:0]      es_req_wdata,
  input  logic [DATA_W/8-1:0]    es_req_wstrb,
  input  logic                   flush,
  output logic                   data_req,
  output logic                   data_wr,
  output logic [1:0]             data_size,
  output logic [ADDR_W-1:0]      data_addr,
  output logic [DATA_W-1:0]      data_wdata,
  output logic [DATA_W/8-1:0]    data_wstrb,
  input  logic                   data_addr_ok,
  input  logic                   data_data_ok,
  input  logic [DATA_W-1:0]      data_rdata,
  output logic                   ms_resp_valid,
  output logic                   ms_resp_wr,
  output logic [DATA_W-1:0]      ms_resp_rdata,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   idle,
  output logic                   proto_err,
  output logic [31:0]            perf_stall_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = DATA_W / 8;

  state_t              state;
  logic                hold_wr;
  logic [1:0]          hold_size;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W-1:0]   hold_wdata;
  logic [SW-1:0]       hold_wstrb;
  logic                hold_kill;

  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                head_wr;
  logic                head_kill;

  logic                addr_hs;
  logic                accept;
  logic                resp_pop;

  // Gating on fifo_full is what keeps a push-when-full impossible.
  assign data_req   = (state == ST_HOLD) && !fifo_full;
  assign data_wr    = hold_wr;
  assign data_size  = hold_size;
  assign data_addr  = hold_addr;
  assign data_wdata = hold_wdata;
  assign data_wstrb = hold_wstrb;

  assign addr_hs     = data_req && data_addr_ok;
  assign accept      = es_req_valid && es_req_ready;
  assign resp_pop    = data_data_ok && !fifo_empty;
  assign outstanding = fifo_count;
  assign idle        = (state == ST_IDLE) && fifo_empty;

  // In HOLD a new op can only be taken in the cycle the held one leaves on
  // addr_ok; reset forces ready low so no op is accepted while clearing.
  always_comb begin
    es_req_ready = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: es_req_ready = !flush;
        ST_HOLD: es_req_ready = addr_hs && !flush;
        default: es_req_ready = 1'b0;
      endcase
    end
  end

  // A flush that coincides with the push is folded into the pushed entry,
  // since kill_all only reaches entries already stored.
  req_track_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (addr_hs),
    .push_wr   (hold_wr),
    .push_kill (hold_kill || flush),
    .pop       (resp_pop),
    .kill_all  (flush),
    .head_wr   (head_wr),
    .head_kill (head_kill),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Issue FSM and hold register. A held request is never withdrawn by a
  // flush; it is only marked so its eventual response is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      hold_wr    <= 1'b0;
      hold_size  <= SIZE_B;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_wstrb <= '0;
      hold_kill  <= 1'b0;
    end else begin
      if (accept) begin
        hold_wr    <= es_req_wr;
        hold_size  <= es_req_size;
        hold_addr  <= es_req_addr;
        hold_wdata <= es_req_wdata;
        hold_wstrb <= es_req_wstrb;
        hold_kill  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (accept) begin
            state <= ST_HOLD;
          end else if (addr_hs) begin
            state <= ST_IDLE;
          end else if (flush) begin
            hold_kill <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response register. The kill check includes a same-cycle flush so a
  // flush racing data_ok for the head entry still swallows it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_resp_valid <= 1'b0;
      ms_resp_wr    <= 1'b0;
      ms_resp_rdata <= '0;
    end else begin
      ms_resp_valid <= resp_pop && !(head_kill || flush);
      ms_resp_wr    <= resp_pop && head_wr;
      if (resp_pop) begin
        ms_resp_rdata <= data_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (data_data_ok && fifo_empty) begin
      proto_err <= 1'b1;
    end
  end

`ifdef MEM_REQ_STALL_CNT_EN
  // Counts cycles where a request is waiting, either on the bus or
  // behind a full tracking FIFO; wraps at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
    end else if ((data_req && !data_addr_ok) ||
                 ((state == ST_HOLD) && fifo_full)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_req_tracker.sv
// tb_mem_req_tracker
// Directed bench for mem_req_tracker with a response scoreboard: expected
// responses are queued when data_ok is driven, and a monitor pops and
// compares on every ms_resp_valid pulse.
module tb_mem_req_tracker;
  import mem_req_tracker_pkg::*;

  localparam int DEPTH = 4;
`ifdef MEM_REQ_STALL_CNT_EN
  localparam int STALL_EXP = 7;
`else
  localparam int STALL_EXP = 0;
`endif

  logic        clk;
  logic        reset;
  logic        es_req_valid;
  logic        es_req_ready;
  logic        es_req_wr;
  logic [1:0]  es_req_size;
  logic [31:0] es_req_addr;
  logic [31:0] es_req_wdata;
  logic [3:0]  es_req_wstrb;
  logic        flush;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        ms_resp_valid;
  logic        ms_resp_wr;
  logic [31:0] ms_resp_rdata;
  logic [2:0]  outstanding;
  logic        idle;
  logic        proto_err;
  logic [31:0] perf_stall_cnt;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp;
  int   total;
  int   bad;

  mem_req_tracker #(
    .DEPTH  (DEPTH),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .es_req_valid   (es_req_valid),
    .es_req_ready   (es_req_ready),
    .es_req_wr      (es_req_wr),
    .es_req_size    (es_req_size),
    .es_req_addr    (es_req_addr),
    .es_req_wdata   (es_req_wdata),
    .es_req_wstrb   (es_req_wstrb),
    .flush          (flush),
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_size      (data_size),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_wstrb     (data_wstrb),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata),
    .ms_resp_valid  (ms_resp_valid),
    .ms_resp_wr     (ms_resp_wr),
    .ms_resp_rdata  (ms_resp_rdata),
    .outstanding    (outstanding),
    .idle           (idle),
    .proto_err      (proto_err),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [1:0] s,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] st);
    es_req_valid = v;
    es_req_wr    = w;
    es_req_size  = s;
    es_req_addr  = a;
    es_req_wdata = d;
    es_req_wstrb = st;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic pushExp(input logic w, input logic [31:0] d);
    exp_t e;
    e.wr    = w;
    e.rdata = d;
    sb.push_back(e);
  endtask

  // Response monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ms_resp_valid === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL resp_unexpected actual wr=%0b rdata=%08h required no pulse",
                 ms_resp_wr, ms_resp_rdata);
      end else begin
        mon_exp = sb.pop_front();
        if (ms_resp_wr !== mon_exp.wr || ms_resp_rdata !== mon_exp.rdata) begin
          bad++;
          $display("[TB] FAIL resp_data actual wr=%0b rdata=%08h required wr=%0b rdata=%08h",
                   ms_resp_wr, ms_resp_rdata, mon_exp.wr, mon_exp.rdata);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    flush = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    applyStimulus(1'b0, 1'b0, SIZE_B, 32'h0, 32'h0, 4'h0);

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_idle", 64'(idle), 64'd1);
    checkOutput("rst_outstanding", 64'(outstanding), 64'd0);
    checkOutput("rst_ready", 64'(es_req_ready), 64'd0);
    checkOutput("rst_data_req", 64'(data_req), 64'd0);
    checkOutput("rst_resp_valid", 64'(ms_resp_valid), 64'd0);
    checkOutput("rst_proto_err", 64'(proto_err), 64'd0);
    checkOutput("rst_perf", 64'(perf_stall_cnt), 64'd0);
    reset = 1'b0;
    tick();

    // Single load
    $display("[TB] single load");
    applyStimulus(1'b1, 1'b0, SIZE_W, 32'h1000, 32'h0, 4'hF);
    @(negedge clk);
    checkOutput("t1_ready", 64'(es_req_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 1'b0, SIZE_B, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t1_data_req", 64'(data_req), 64'd1);
    checkOutput("t1_data_addr", 64'(data_addr), 64'h1000);
    checkOutput("t1_data_wr", 64'(data_wr), 64'd0);
    checkOutput("t1_data_size", 64'(data_size), 64'(SIZE_W));
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    @(negedge clk);
    checkOutput("t1_outstanding", 64'(outstanding), 64'd1);
    checkOutput("t1_req_drop", 64'(data_req), 64'd0);
    checkOutput("t1_not_idle", 64'(idle), 64'd0);
    tick();
    tick();
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEADBEEF;
    pushExp(1'b0, 32'hDEADBEEF);
    tick();
    data_data_ok = 1'b0;
    @(negedge clk);
    checkOutput("t1_drained", 64'(outstanding), 64'd0);
    tick();
    checkOutput("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Back-to-back stores, fill FIFO, fifth op waits for first data_ok
    $display("[TB] back-to-back stores");
    applyStimulus(1'b1, 1'b1, SIZE_W, 32'h2000, 32'h50000000, 4'hF);
    tick();
    data_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, SIZE_W, 32'h2000 + 32'(4 * (i + 1)),
                    32'h50000000 + 32'(i + 1), 4'hF);
      @(negedge clk);
      checkOutput($sformatf("t2_out_step%0d", i), 64'(outstanding), 64'(i));
      checkOutput($sformatf("t2_ready_step%0d", i), 64'(es_req_ready), 64'd1);
      tick();
    end
    applyStimulus(1'b0, 1'b0, SIZE_B, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("t2_full", 64'(outstanding), 64'd4);
    checkOutput("t2_req_gated", 64'(data_req), 64'd0);
    checkOutput("t2_ready_full", 64'(es_req_ready), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("t2_still_gated", 64'(data_req), 64'd0);
    checkOutput("t2_hold_addr", 64'(data_addr), 64'h2010);
    checkOutput("t2_hold_wdata", 64'(data_wdata), 64'h50000004);
    checkOutput("t2_hold_wstrb", 64'(data_wstrb), 64'hF);
    checkOutput("t2_hold_wr", 64'(data_wr), 64'd1);
    data_data_ok = 1'b1;
    data_rdata   = 32'h000000A0;
    pushExp(1'b1, 32'h000000A0);
    tick();
    data_data_ok = 1'b0;
    @(negedge clk);
    checkOutput("t2_after_pop", 64'(outstanding), 64'd3);
    checkOutput("t2_req_reissue", 64'(data_req), 64'd1);
    tick();
    data_addr_ok = 1'b0;
    @(negedge clk);
    checkOutput("t2_refull", 64'(outstanding), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      data_data_ok = 1'b1;
      data_rdata   = 32'hA0 + 32'(i);
      pushExp(1'b1, 32'hA0 + 32'(i));
      tick();
    end
    data_data_ok = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("t2_drained", 64'(outstanding), 64'd0);
    checkOutput("t2_idle", 64'(idle), 64'd1);
    checkOutput("t2_sb_empty", 64'(sb.size()), 64'd0);

    // Flush with two loads in flight
    $display("[TB] flush in flight");
    applyStimulus(1'b1, 1'b0, SIZE_W, 32'h3000, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b1, 1'b0, SIZE_W, 32'h3004, 32'h0, 4'hF);
    data_addr_ok = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, SIZE_B, 32'h0, 32'h0, 4'h0);
    tick();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("t3_out2", 64'(outstanding), 64'd2);
    checkOutput("t3_ready_flush", 64'(es_req_ready), 64'd0);
    tick();
    flush = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'h55555555;
    tick();
    tick();
    data_data_ok = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("t3_drained", 64'(outstanding), 64'd0);
    applyStimulus(1'b1, 1'b0, SIZE_W, 32'h3100, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, SIZE_B, 32'h0, 32'h0, 4'h0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = 32'hCAFEF00D;
    pushExp(1'b0, 32'hCAFEF00D);
    tick();
    data_data_ok = 1'b0;
    tick();
    checkOutput("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Flush in the same cycle as data_ok for the head entry
    $display("[TB] flush racing data_ok");
    applyStimulus(1'b1, 1'b0, SIZE_W, 32'h3200, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, SIZE_B, 32'h0, 32'h0, 4'h0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    flush        = 1'b1;
    data_rdata   = 32'h12345678;
    tick();
    data_data_ok = 1'b0;
    flush        = 1'b0;
    @(negedge clk);
    checkOutput("t3b_no_pulse", 64'(ms_resp_valid), 64'd0);
    checkOutput("t3b_drained", 64'(outstanding), 64'd0);
    tick();

    // Flush while held without addr_ok
    $display("[TB] flush in hold");
    applyStimulus(1'b1, 1'b0, SIZE_H, 32'h4000, 32'h0, 4'h3);
    tick();
    applyStimulus(1'b0, 1'b0, SIZE_B, 32'h0, 32'h0, 4'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    checkOutput("t4_req_kept", 64'(data_req), 64'd1);
    checkOutput("t4_addr_kept", 64'(data_addr), 64'h4000);
    tick();
    @(negedge clk);
    checkOutput("t4_addr_kept2", 64'(data_addr), 64'h4000);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    @(negedge clk);
    checkOutput("t4_out1", 64'(outstanding), 64'd1);
    data_data_ok = 1'b1;
    data_rdata   = 32'h0BADF00D;
    tick();
    data_data_ok = 1'b0;
    @(negedge clk);
    checkOutput("t4_no_pulse", 64'(ms_resp_valid), 64'd0);
    checkOutput("t4_drained", 64'(outstanding), 64'd0);
    tick();

    // Protocol error: data_ok with nothing outstanding
    $display("[TB] protocol error");
    @(negedge clk);
    checkOutput("t5_pre", 64'(proto_err), 64'd0);
    data_data_ok = 1'b1;
    data_rdata   = 32'h77777777;
    tick();
    data_data_ok = 1'b0;
    @(negedge clk);
    checkOutput("t5_err", 64'(proto_err), 64'd1);
    checkOutput("t5_out0", 64'(outstanding), 64'd0);
    checkOutput("t5_no_pulse", 64'(ms_resp_valid), 64'd0);
    tick();
    @(negedge clk);
    checkOutput("t5_sticky", 64'(proto_err), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_cleared", 64'(proto_err), 64'd0);
    checkOutput("t5_idle", 64'(idle), 64'd1);
    tick();

    // Stall counter: 7 cycles of data_req without addr_ok
    $display("[TB] stall counter");
    applyStimulus(1'b1, 1'b0, SIZE_W, 32'h6000, 32'h0, 4'hF);
    tick();
    applyStimulus(1'b0, 1'b0, SIZE_B, 32'h0, 32'h0, 4'h0);
    repeat (7) tick();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    @(negedge clk);
    checkOutput("t6_stall_cnt", 64'(perf_stall_cnt), 64'(STALL_EXP));
    data_data_ok = 1'b1;
    data_rdata   = 32'h60606060;
    pushExp(1'b0, 32'h60606060);
    tick();
    data_data_ok = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("t6_stall_final", 64'(perf_stall_cnt), 64'(STALL_EXP));
    checkOutput("t6_sb_empty", 64'(sb.size()), 64'd0);
    checkOutput("t6_idle", 64'(idle), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
